// File: rtl/cpc_bus_pkg.sv
// ----------------------------------------------------------------------------
// cpc_bus_pkg
// Definitions shared by the CPU bus-side blocks.
//   state_e     : read-data arbiter state (IDLE, WAIT, DONE)
//   DEFAULT_BUS : value seen on an undriven (pulled-up) data bus
//   TCNT_W      : width of the wait-state counter (covers TIMEOUT up to 255)
// ----------------------------------------------------------------------------
package cpc_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [7:0] DEFAULT_BUS = 8'hFF;
    localparam int         TCNT_W      = 8;

endpackage : cpc_bus_pkg

// File: rtl/prio_enc.sv
// ----------------------------------------------------------------------------
// prio_enc
// Purely combinational lowest-index priority encoder.
//   req   in  N   request vector
//   index out IW  index of the lowest set bit (0 when none set)
//   any   out 1   at least one bit set
//   multi out 1   more than one bit set
// ----------------------------------------------------------------------------
module prio_enc #(
    parameter int N  = 5,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic [IW-1:0] index,
    output logic          any,
    output logic          multi
);

    always_comb begin
        index = '0;
        any   = 1'b0;
        multi = 1'b0;
        // Ascending scan: the first hit fixes the index, any later hit
        // means more than one request is present.
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                if (any) begin
                    multi = 1'b1;
                end else begin
                    index = IW'(i);
                end
                any = 1'b1;
            end
        end
    end

endmodule : prio_enc

// File: rtl/cpu_rdata_arbiter.sv
// ----------------------------------------------------------------------------
// cpu_rdata_arbiter
// Registered read-data arbiter between N address-decoded sources and the
// Z80 data-in bus, with wait-state handshake, timeout and conflict counting.
//   clk          in  1     system clock
//   reset        in  1     synchronous active-high reset
//   rd_req       in  1     CPU read cycle active (level, held for the read)
//   src_e        in  N     per-source enable (decoded hit)
//   src_d        in  N*W   packed source data, source i at [i*W +: W]
//   src_rdy      in  N     per-source data valid (only the winner matters)
//   D            out W     registered read data
//   wait_n       out 1     active-low WAIT to the CPU
//   d_valid      out 1     one-cycle pulse when D is updated
//   timeout      out 1     one-cycle pulse when DEFAULT returned on timeout
//   conflict     out 1     sticky: more than one src_e seen at read start
//   conflict_clr in  1     clears conflict and conflict_cnt
//   conflict_cnt out CNTW  saturating count of conflicting reads
// ----------------------------------------------------------------------------
module cpu_rdata_arbiter
    import cpc_bus_pkg::*;
#(
    parameter int           N       = 5,
    parameter int           W       = 8,
    parameter logic [W-1:0] DEFAULT = W'(DEFAULT_BUS),
    parameter int           TIMEOUT = 15,
    parameter int           CNTW    = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rd_req,
    input  logic [N-1:0]    src_e,
    input  logic [N*W-1:0]  src_d,
    input  logic [N-1:0]    src_rdy,
    output logic [W-1:0]    D,
    output logic            wait_n,
    output logic            d_valid,
    output logic            timeout,
    output logic            conflict,
    input  logic            conflict_clr,
    output logic [CNTW-1:0] conflict_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    // Unpack the source data bus into an array for indexed selection.
    logic [W-1:0] src_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign src_arr[gi] = src_d[gi*W +: W];
        end
    endgenerate

    // Encoder on the live enables; only consulted when leaving IDLE.
    logic [IW-1:0] enc_idx;
    logic          enc_any;
    logic          enc_multi;

    prio_enc #(
        .N  (N),
        .IW (IW)
    ) u_prio_enc (
        .req   (src_e),
        .index (enc_idx),
        .any   (enc_any),
        .multi (enc_multi)
    );

    state_e            state_q,    state_d;
    logic [IW-1:0]     win_q,      win_d;
    logic [TCNT_W-1:0] tcnt_q,     tcnt_d;
    logic [W-1:0]      data_q,     data_d;
    logic              wait_n_q,   wait_n_d;
    logic              dvalid_q,   dvalid_d;
    logic              tmo_q,      tmo_d;
    logic              conf_q,     conf_d;
    logic [CNTW-1:0]   ccnt_q,     ccnt_d;

    logic timeout_hit;

    // Last permitted wait cycle; a TIMEOUT of 0 never fires.
    always_comb begin
        timeout_hit = 1'b0;
        if (TIMEOUT != 0) begin
            timeout_hit = (tcnt_q == TCNT_W'(TIMEOUT - 1));
        end
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_q;
        tcnt_d   = tcnt_q;
        data_d   = data_q;
        wait_n_d = wait_n_q;
        dvalid_d = 1'b0;
        tmo_d    = 1'b0;
        conf_d   = conf_q;
        ccnt_d   = ccnt_q;

        if (conflict_clr) begin
            conf_d = 1'b0;
            ccnt_d = '0;
        end

        unique case (state_q)
            ST_IDLE: begin
                wait_n_d = 1'b1;
                if (rd_req) begin
                    win_d = enc_idx;
                    // A new conflict overrides a same-cycle clear, so the
                    // count restarts at one rather than zero.
                    if (enc_multi) begin
                        conf_d = 1'b1;
                        if (conflict_clr) begin
                            ccnt_d = CNTW'(1);
                        end else if (ccnt_q != {CNTW{1'b1}}) begin
                            ccnt_d = ccnt_q + CNTW'(1);
                        end
                    end
                    if (!enc_any) begin
                        data_d   = DEFAULT;
                        dvalid_d = 1'b1;
                        state_d  = ST_DONE;
                    end else if (src_rdy[enc_idx]) begin
                        data_d   = src_arr[enc_idx];
                        dvalid_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        wait_n_d = 1'b0;
                        tcnt_d   = '0;
                        state_d  = ST_WAIT;
                    end
                end
            end

            ST_WAIT: begin
                // Abort beats data, data beats timeout.
                if (!rd_req) begin
                    wait_n_d = 1'b1;
                    state_d  = ST_IDLE;
                end else if (src_rdy[win_q]) begin
                    data_d   = src_arr[win_q];
                    wait_n_d = 1'b1;
                    dvalid_d = 1'b1;
                    state_d  = ST_DONE;
                end else if (timeout_hit) begin
                    data_d   = DEFAULT;
                    wait_n_d = 1'b1;
                    dvalid_d = 1'b1;
                    tmo_d    = 1'b1;
                    state_d  = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            ST_DONE: begin
                wait_n_d = 1'b1;
                if (!rd_req) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                wait_n_d = 1'b1;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            win_q    <= '0;
            tcnt_q   <= '0;
            data_q   <= DEFAULT;
            wait_n_q <= 1'b1;
            dvalid_q <= 1'b0;
            tmo_q    <= 1'b0;
            conf_q   <= 1'b0;
            ccnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            tcnt_q   <= tcnt_d;
            data_q   <= data_d;
            wait_n_q <= wait_n_d;
            dvalid_q <= dvalid_d;
            tmo_q    <= tmo_d;
            conf_q   <= conf_d;
            ccnt_q   <= ccnt_d;
        end
    end

    assign D            = data_q;
    assign wait_n       = wait_n_q;
    assign d_valid      = dvalid_q;
    assign timeout      = tmo_q;
    assign conflict     = conf_q;
    assign conflict_cnt = ccnt_q;

endmodule : cpu_rdata_arbiter
